// File: rtl/psum_accumulator.sv
// Partial-sum group accumulator: sums len consecutive valid beats, saturates the
// group total to BITWIDTH and queues it in a 2-entry valid/ready output buffer.
module psum_accumulator #(
  parameter int BITWIDTH = 32,
  parameter int ACC_BITS = 40,
  parameter int LEN_BITS = 8
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                en,
  input  logic [BITWIDTH-1:0] din,
  input  logic                valid,
  input  logic [LEN_BITS-1:0] len,
  output logic [BITWIDTH-1:0] dout,
  output logic                dvalid,
  input  logic                dready,
  output logic                sat,
  output logic                overflow
);

  typedef enum logic {IDLE, ACCUM} state_t;

  typedef struct packed {
    logic [BITWIDTH-1:0] data;
    logic                sat;
  } entry_t;

  localparam logic [ACC_BITS-1:0] SAT_MAX = {{(ACC_BITS-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
  localparam logic [ACC_BITS-1:0] SAT_MIN = {{(ACC_BITS-BITWIDTH+1){1'b1}}, {(BITWIDTH-1){1'b0}}};

  state_t              state_q, state_d;
  logic [ACC_BITS-1:0] acc_q, acc_d;
  logic [LEN_BITS-1:0] count_q, count_d;
  logic [LEN_BITS-1:0] grp_len_q, grp_len_d;
  logic [ACC_BITS-1:0] din_ext, sum;
  logic                complete;
  logic                beat;

  entry_t              mem [2];
  entry_t              new_entry;
  logic                rd_ptr, wr_ptr;
  logic [1:0]          occ;
  logic                full, push, pop;

  assign din_ext = {{(ACC_BITS-BITWIDTH){din[BITWIDTH-1]}}, din};
  assign beat    = en & valid;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    grp_len_d = grp_len_q;
    sum       = din_ext;
    complete  = 1'b0;
    if (beat) begin
      unique case (state_q)
        IDLE: begin
          grp_len_d = (len == '0) ? LEN_BITS'(1) : len;
          if (len <= LEN_BITS'(1)) begin
            complete = 1'b1;
          end else begin
            acc_d   = din_ext;
            count_d = LEN_BITS'(1);
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          sum = acc_q + din_ext;
          if ((LEN_BITS+1)'(count_q) + (LEN_BITS+1)'(1) == (LEN_BITS+1)'(grp_len_q)) begin
            complete = 1'b1;
            acc_d    = '0;
            count_d  = '0;
            state_d  = IDLE;
          end else begin
            acc_d   = sum;
            count_d = count_q + LEN_BITS'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      count_q   <= '0;
      grp_len_q <= '0;
    end else if (!en) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      count_q   <= '0;
      grp_len_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      grp_len_q <= grp_len_d;
    end
  end

  // Clamp the wide sum into the signed BITWIDTH range.
  always_comb begin
    new_entry = '0;
    if ($signed(sum) > $signed(SAT_MAX)) begin
      new_entry.data = SAT_MAX[BITWIDTH-1:0];
      new_entry.sat  = 1'b1;
    end else if ($signed(sum) < $signed(SAT_MIN)) begin
      new_entry.data = SAT_MIN[BITWIDTH-1:0];
      new_entry.sat  = 1'b1;
    end else begin
      new_entry.data = sum[BITWIDTH-1:0];
    end
  end

  assign dvalid = (occ != 2'd0);
  assign full   = (occ == 2'd2);
  assign pop    = dvalid & dready;
  // When full, a simultaneous pop frees the slot the write pointer already targets.
  assign push   = complete & (~full | pop);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      occ      <= 2'd0;
      overflow <= 1'b0;
    end else if (!en) begin
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      occ      <= 2'd0;
      overflow <= 1'b0;
    end else begin
      if (pop)  rd_ptr <= ~rd_ptr;
      if (push) wr_ptr <= ~wr_ptr;
      unique case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
      if (complete && full && !pop) overflow <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; occupancy alone decides what is visible.
  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  assign dout = dvalid ? mem[rd_ptr].data : '0;
  assign sat  = dvalid ? mem[rd_ptr].sat  : 1'b0;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed self-checking bench for psum_accumulator with hand-computed results.
module tb_psum_accumulator;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        en;
  logic [31:0] din;
  logic        valid;
  logic [7:0]  len;
  logic [31:0] dout;
  logic        dvalid;
  logic        dready;
  logic        sat;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  psum_accumulator #(.BITWIDTH(32), .ACC_BITS(40), .LEN_BITS(8)) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .en       (en),
    .din      (din),
    .valid    (valid),
    .len      (len),
    .dout     (dout),
    .dvalid   (dvalid),
    .dready   (dready),
    .sat      (sat),
    .overflow (overflow)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one cycle of input, then sample 1 time unit after the rising edge.
  task automatic beat(input logic v, input logic [31:0] d);
    valid = v;
    din   = d;
    @(posedge aclk);
    #1;
  endtask

  initial begin
    aresetn = 1'b0;
    en      = 1'b1;
    din     = '0;
    valid   = 1'b0;
    len     = 8'd0;
    dready  = 1'b1;
    #12;
    check("reset_dout",     dout,     32'd0);
    check("reset_dvalid",   dvalid,   1'b0);
    check("reset_sat",      sat,      1'b0);
    check("reset_overflow", overflow, 1'b0);
    @(negedge aclk);
    aresetn = 1'b1;

    // Group of four.
    len = 8'd4;
    beat(1'b1, 32'd10); check("g4_b1_dvalid", dvalid, 1'b0);
    beat(1'b1, 32'd20); check("g4_b2_dvalid", dvalid, 1'b0);
    beat(1'b1, 32'd30); check("g4_b3_dvalid", dvalid, 1'b0);
    beat(1'b1, 32'd40);
    check("g4_dvalid", dvalid, 1'b1);
    check("g4_dout",   dout,   32'd100);
    check("g4_sat",    sat,    1'b0);
    beat(1'b0, 32'd0);  check("g4_pulse_end", dvalid, 1'b0);

    // len=0 acts as 1, back-to-back results.
    len = 8'd0;
    beat(1'b1, 32'd7);
    check("l0_a_dvalid", dvalid, 1'b1);
    check("l0_a_dout",   dout,   32'd7);
    beat(1'b1, 32'hFFFF_FFFD);
    check("l0_b_dvalid", dvalid, 1'b1);
    check("l0_b_dout",   dout,   32'hFFFF_FFFD);
    beat(1'b0, 32'd0);  check("l0_end", dvalid, 1'b0);

    // Positive and negative saturation.
    len = 8'd2;
    beat(1'b1, 32'h7FFF_FFFF);
    beat(1'b1, 32'h7FFF_FFFF);
    check("satp_dout", dout, 32'h7FFF_FFFF);
    check("satp_sat",  sat,  1'b1);
    beat(1'b1, 32'h8000_0000); check("satn_mid_dvalid", dvalid, 1'b0);
    beat(1'b1, 32'h8000_0000);
    check("satn_dout", dout, 32'h8000_0000);
    check("satn_sat",  sat,  1'b1);
    beat(1'b0, 32'd0);
    check("sat_end", dvalid, 1'b0);
    check("sat_end_sat", sat, 1'b0);

    // Back-pressure and overflow.
    dready = 1'b0;
    len    = 8'd1;
    beat(1'b1, 32'd1);
    beat(1'b1, 32'd2);
    check("bp_ovf_before", overflow, 1'b0);
    beat(1'b1, 32'd3);
    check("bp_ovf",    overflow, 1'b1);
    check("bp_head",   dout,     32'd1);
    dready = 1'b1;
    beat(1'b0, 32'd0);
    check("bp_second", dout,     32'd2);
    check("bp_sec_dv", dvalid,   1'b1);
    beat(1'b0, 32'd0);
    check("bp_empty",  dvalid,   1'b0);
    check("bp_sticky", overflow, 1'b1);

    // Abandoned group via enable low.
    len = 8'd3;
    beat(1'b1, 32'd5);
    beat(1'b1, 32'd5);
    en = 1'b0;
    beat(1'b1, 32'd9);
    check("en0_ovf",    overflow, 1'b0);
    check("en0_dvalid", dvalid,   1'b0);
    en  = 1'b1;
    len = 8'd2;
    beat(1'b1, 32'd1); check("en_b1_dvalid", dvalid, 1'b0);
    beat(1'b1, 32'd1);
    check("en_dout",   dout,     32'd2);
    check("en_dvalid", dvalid,   1'b1);
    check("en_ovf",    overflow, 1'b0);
    beat(1'b0, 32'd0); check("en_end", dvalid, 1'b0);

    // Valid gaps, mid-group len change, then async reset while holding a result.
    dready = 1'b0;
    len    = 8'd3;
    beat(1'b1, 32'd4);
    len = 8'd1;
    beat(1'b0, 32'd99);
    beat(1'b0, 32'd99);
    beat(1'b1, 32'd5); check("gap_mid_dvalid", dvalid, 1'b0);
    beat(1'b1, 32'd6);
    check("gap_dout",   dout,   32'd15);
    check("gap_dvalid", dvalid, 1'b1);
    #2;
    aresetn = 1'b0;
    #1;
    check("arst_dvalid", dvalid, 1'b0);
    check("arst_dout",   dout,   32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    valid   = 1'b0;
    @(posedge aclk); #1;
    check("arst_hold", dvalid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Sits directly downstream of the delay_fifo stage.
- Consumes the time-aligned partial-sum stream (din/valid) and sums groups of len consecutive valid beats into one signed result.
- Saturates each result to BITWIDTH and presents it on a 2-entry valid/ready output buffer for the activation/write-back stage.
- Flags results lost to back-pressure.

Parameters:
BITWIDTH, 32, width of input partial sums and of output results (two's complement)
ACC_BITS, 40, internal accumulator width; must be >= BITWIDTH + 8
LEN_BITS, 8, width of the runtime group-length input

Ports:
aclk  input  1  clock, all logic on rising edge
aresetn  input  1  asynchronous active-low reset
en  input  1  stage enable; low = synchronous clear of all state, inputs ignored
din  input  BITWIDTH  signed partial sum from upstream delay stage
valid  input  1  din qualifier; no back-pressure to upstream, every beat with en=1 is consumed
len  input  LEN_BITS  beats per group; sampled on the first beat of each group; 0 treated as 1
dout  output  BITWIDTH  saturated group sum, head of output buffer
dvalid  output  1  dout holds a valid result
dready  input  1  downstream accepts dout when dvalid&dready
sat  output  1  the result at dout was saturated (travels with the entry)
overflow  output  1  sticky: a completed result was dropped because the buffer was full

Behaviour:
- Reset (aresetn=0, async): acc=0, count=0, grp_len=0, buffer empty, dout=0, dvalid=0, sat=0, overflow=0.
- en=0 at a clock edge: same clear as reset, performed synchronously. valid and dready are ignored that cycle.
- Accumulation FSM, two states:
  - IDLE (count=0): on a valid beat, grp_len <= (len==0 ? 1 : len), acc <= sext(din), count <= 1, go to ACCUM. If grp_len resolves to 1, the group completes on that same beat instead.
  - ACCUM: on each valid beat, acc <= acc + sext(din), count <= count+1. The beat where count+1 == grp_len completes the group: acc and count return to 0, state returns to IDLE.
  - Beats with valid=0 hold all state; there are no timeouts.
  - len changes mid-group have no effect until the next group starts.
- Completion value = acc + sext(din) of the final beat, computed at ACC_BITS width; the ACC_BITS accumulator wraps.
- Saturation to BITWIDTH signed:
  - value > 2^(BITWIDTH-1)-1 -> max positive
  - value < -2^(BITWIDTH-1) -> min negative
  - entry sat bit = 1 when either clamp applies.
- Latency: the result is visible on dout/dvalid in the cycle after the clock edge that sampled the final beat (1 cycle).
- Output buffer: 2-entry FIFO, dout/sat driven from the head entry. dout=0 and sat=0 when empty.
  - Pop on dvalid&dready.
  - Push on completion.
  - Push and pop in the same cycle are both performed; occupancy is unchanged and ordering is preserved.
  - Push with the buffer full and no pop: the new result is discarded, buffer unchanged, overflow <= 1.
  - overflow clears only on reset or en=0.
- The next group may start on the beat immediately after a completion; back-to-back groups of length 1 produce one result per cycle.

Test Plan:
- len=4, valid beats din=10,20,30,40, dready=1 -> exactly one dvalid pulse the cycle after beat 4, dout=100, sat=0.
- len=0, din=7 then din=-3 on consecutive cycles, dready=1 -> dout=7 then dout=-3 (0xFFFFFFFD) on consecutive cycles.
- BITWIDTH=32, len=2, din=0x7FFFFFFF twice -> dout=0x7FFFFFFF, sat=1. Repeat with 0x80000000 twice -> dout=0x80000000, sat=1.
- len=1, dready=0, valid for 3 beats din=1,2,3 -> buffer holds 1,2, overflow=1. Then dready=1 -> dout=1 then 2, dvalid low afterwards, overflow stays 1.
- len=3, two beats din=5,5, then en=0 one cycle, then len=2 with beats 1,1 -> single result dout=2; the abandoned group leaves no output; overflow=0.
- Mid-group valid gaps: len=3, beats 4,x(valid=0),x,5,6 -> dout=15. Also assert aresetn=0 while dvalid=1 -> dvalid and dout drop to 0 immediately, without waiting for a clock edge.
